// File: rtl/sw_alloc_ctrl_pkg.sv
// Shared constants and types for the separable switch allocator.
package vr_sa_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned NUM_VC     = 4;
  localparam int unsigned BUF_DEPTH  = 4;
  localparam int unsigned LOCAL_PORT = NUM_PORTS - 1;
  localparam int unsigned CREDIT_W   = $clog2(BUF_DEPTH + 1);

  typedef logic [CREDIT_W-1:0]  credit_t;
  typedef logic [NUM_PORTS-1:0] port_onehot_t;
  typedef logic [NUM_VC-1:0]    vc_onehot_t;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/sw_alloc_ctrl_if.sv
// Request/grant/credit bundle between the router pipeline and the switch allocator.
interface sw_alloc_ctrl_if
  import vr_sa_pkg::*;
#(
  parameter int unsigned NUM_PORTS = vr_sa_pkg::NUM_PORTS,
  parameter int unsigned NUM_VC    = vr_sa_pkg::NUM_VC
);

  logic [NUM_PORTS*NUM_VC-1:0]                sa_req;
  logic [NUM_PORTS*NUM_VC-1:0][NUM_PORTS-1:0] sa_req_port;
  logic [NUM_PORTS-2:0]                       dwnstr_credit_increment;
  logic [NUM_PORTS-1:0]                       sa_grant_valid;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]           sa_grant_vc;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        sa_allocated_ports;
  logic [NUM_PORTS-2:0]                       credit_avail;
  logic                                       credit_overflow;

  modport master (
    output sa_req, sa_req_port, dwnstr_credit_increment,
    input  sa_grant_valid, sa_grant_vc, sa_allocated_ports, credit_avail, credit_overflow
  );

  modport slave (
    input  sa_req, sa_req_port, dwnstr_credit_increment,
    output sa_grant_valid, sa_grant_vc, sa_allocated_ports, credit_avail, credit_overflow
  );

endinterface

// File: rtl/sw_alloc_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on update_en.
module sa_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;

  always_comb begin
    grant      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && req[(32'(r_ptr) + i) % N]) begin
        w_found                         = 1'b1;
        grant[(32'(r_ptr) + i) % N]     = 1'b1;
        w_next_ptr                      = PW'((32'(r_ptr) + i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= '0;
    else if (update_en && w_found)
      r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/sw_alloc_ctrl.sv
// Separable input-first switch allocator with downstream credit counters.
// Optional SA_LOCAL_PRIO_EN: local input wins stage 2 outright; RR pointer moves only on non-local wins.
module sw_alloc_ctrl
  import vr_sa_pkg::*;
#(
  parameter int unsigned NUM_PORTS = vr_sa_pkg::NUM_PORTS,
  parameter int unsigned NUM_VC    = vr_sa_pkg::NUM_VC,
  parameter int unsigned BUF_DEPTH = vr_sa_pkg::BUF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  sw_alloc_ctrl_if.slave  bus
);

  localparam int unsigned NP = NUM_PORTS;
  localparam int unsigned NC = NUM_PORTS - 1;
  localparam int unsigned LP = NUM_PORTS - 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [NC-1:0][CW-1:0]     r_credit;
  logic                      r_credit_overflow;
  logic [NP-1:0]             r_grant_valid;
  logic [NP-1:0][NUM_VC-1:0] r_grant_vc;
  logic [NP-1:0][NP-1:0]     r_alloc;

  logic [NC-1:0]             w_avail;
  logic [NP-1:0]             w_port;
  logic [NP-1:0][NUM_VC-1:0] w_elig;
  logic [NP-1:0][NUM_VC-1:0] w_s1_grant;
  logic [NP-1:0][NP-1:0]     w_in_req;
  logic [NP-1:0][NP-1:0]     w_s2_req;
  logic [NP-1:0][NP-1:0]     w_s2_arb_grant;
  logic [NP-1:0][NP-1:0]     w_s2_grant;
  logic [NP-1:0]             w_s2_upd;
  logic [NP-1:0][NP-1:0]     w_alloc;
  logic [NP-1:0]             w_in_win;
  logic [NC-1:0]             w_out_granted;

  always_comb begin
    for (int unsigned o = 0; o < NC; o++)
      w_avail[o] = (r_credit[o] != '0);
  end

  // Malformed destination encodings never become eligible.
  always_comb begin
    w_elig = '0;
    w_port = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        w_port       = bus.sa_req_port[p*NUM_VC + v];
        w_elig[p][v] = bus.sa_req[p*NUM_VC + v] && is_onehot(32'(w_port)) &&
                       (w_port[LP] || (|(w_port[NC-1:0] & w_avail)));
      end
    end
  end

  always_comb begin
    w_in_req = '0;
    for (int unsigned p = 0; p < NP; p++)
      for (int unsigned v = 0; v < NUM_VC; v++)
        if (w_s1_grant[p][v])
          w_in_req[p] = w_in_req[p] | bus.sa_req_port[p*NUM_VC + v];
  end

  always_comb begin
    w_s2_req = '0;
    for (int unsigned o = 0; o < NP; o++)
      for (int unsigned p = 0; p < NP; p++)
        w_s2_req[o][p] = w_in_req[p][o];
  end

  genvar g;
  generate
    for (g = 0; g < NP; g++) begin : g_arb
      sa_rr_arb #(.N(NUM_VC)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .req       (w_elig[g]),
        .update_en (w_in_win[g]),
        .grant     (w_s1_grant[g])
      );
      sa_rr_arb #(.N(NP)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .req       (w_s2_req[g]),
        .update_en (w_s2_upd[g]),
        .grant     (w_s2_arb_grant[g])
      );
    end
  endgenerate

  always_comb begin
    w_s2_grant = '0;
    w_s2_upd   = '0;
    for (int unsigned o = 0; o < NP; o++) begin
`ifdef SA_LOCAL_PRIO_EN
      if (w_s2_req[o][LP]) begin
        w_s2_grant[o]     = '0;
        w_s2_grant[o][LP] = 1'b1;
        w_s2_upd[o]       = 1'b0;
      end else begin
        w_s2_grant[o] = w_s2_arb_grant[o];
        w_s2_upd[o]   = 1'b1;
      end
`else
      w_s2_grant[o] = w_s2_arb_grant[o];
      w_s2_upd[o]   = 1'b1;
`endif
    end
  end

  always_comb begin
    w_alloc       = '0;
    w_in_win      = '0;
    w_out_granted = '0;
    for (int unsigned o = 0; o < NP; o++)
      for (int unsigned p = 0; p < NP; p++)
        w_alloc[p][o] = w_s2_grant[o][p];
    for (int unsigned p = 0; p < NP; p++)
      w_in_win[p] = |w_alloc[p];
    for (int unsigned o = 0; o < NC; o++)
      w_out_granted[o] = |w_s2_grant[o];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_valid <= '0;
      r_grant_vc    <= '0;
      r_alloc       <= '0;
    end else begin
      r_grant_valid <= w_in_win;
      r_alloc       <= w_alloc;
      for (int unsigned p = 0; p < NP; p++)
        r_grant_vc[p] <= w_in_win[p] ? w_s1_grant[p] : '0;
    end
  end

  // A grant and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned o = 0; o < NC; o++)
        r_credit[o] <= CW'(BUF_DEPTH);
      r_credit_overflow <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < NC; o++) begin
        if (w_out_granted[o] && !bus.dwnstr_credit_increment[o])
          r_credit[o] <= r_credit[o] - CW'(1);
        else if (!w_out_granted[o] && bus.dwnstr_credit_increment[o]) begin
          if (r_credit[o] == CW'(BUF_DEPTH))
            r_credit_overflow <= 1'b1;
          else
            r_credit[o] <= r_credit[o] + CW'(1);
        end
      end
    end
  end

  assign bus.sa_grant_valid     = r_grant_valid;
  assign bus.sa_grant_vc        = r_grant_vc;
  assign bus.sa_allocated_ports = r_alloc;
  assign bus.credit_avail       = w_avail;
  assign bus.credit_overflow    = r_credit_overflow;

endmodule

// File: tb/tb_sw_alloc_ctrl.sv
// Directed bench for sw_alloc_ctrl with a cycle-level allocation model and per-cycle compare.
module tb_sw_alloc_ctrl;
  import vr_sa_pkg::*;

  localparam int NP = NUM_PORTS;
  localparam int NV = NUM_VC;
  localparam int NC = NUM_PORTS - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sw_alloc_ctrl_if #(.NUM_PORTS(NP), .NUM_VC(NV)) bus ();

  sw_alloc_ctrl #(.NUM_PORTS(NP), .NUM_VC(NV), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int           m_cnt [NC];
  bit           m_ovf;
  int           m_p1  [NP];
  int           m_p2  [NP];
  bit           m_valid = 1'b0;
  port_onehot_t e_alloc [NP];
  vc_onehot_t   e_vc    [NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Allocation model: plain priority searches over request lists per the allocator rules.
  always @(posedge clk) begin : model
    int want [NP];
    int wvc  [NP];
    int wins [NP];
    int dst, v, q;
    bit forced, inc;
    port_onehot_t pt;
    if (reset) begin
      for (int o = 0; o < NC; o++) m_cnt[o] = BUF_DEPTH;
      for (int p = 0; p < NP; p++) begin
        m_p1[p] = 0; m_p2[p] = 0; e_alloc[p] = '0; e_vc[p] = '0;
      end
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int p = 0; p < NP; p++) begin
        want[p] = -1; wvc[p] = -1;
        for (int i = 0; i < NV; i++) begin
          v  = (m_p1[p] + i) % NV;
          pt = bus.sa_req_port[p*NV + v];
          if (wvc[p] < 0 && bus.sa_req[p*NV + v] && $countones(pt) == 1) begin
            dst = 0;
            for (int b = 0; b < NP; b++) if (pt[b]) dst = b;
            if (dst == NC || m_cnt[dst] > 0) begin
              wvc[p] = v; want[p] = dst;
            end
          end
        end
      end
      for (int o = 0; o < NP; o++) begin
        wins[o] = -1; forced = 1'b0;
`ifdef SA_LOCAL_PRIO_EN
        if (want[NC] == o) begin wins[o] = NC; forced = 1'b1; end
`endif
        for (int i = 0; i < NP; i++) begin
          q = (m_p2[o] + i) % NP;
          if (wins[o] < 0 && want[q] == o) wins[o] = q;
        end
        if (wins[o] >= 0 && !forced) m_p2[o] = (wins[o] + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin e_alloc[p] = '0; e_vc[p] = '0; end
      for (int o = 0; o < NP; o++) begin
        if (wins[o] >= 0) begin
          e_alloc[wins[o]][o]        = 1'b1;
          e_vc[wins[o]][wvc[wins[o]]] = 1'b1;
          m_p1[wins[o]]              = (wvc[wins[o]] + 1) % NV;
        end
      end
      for (int o = 0; o < NC; o++) begin
        inc = bus.dwnstr_credit_increment[o];
        if (wins[o] >= 0 && !inc) m_cnt[o] = m_cnt[o] - 1;
        else if (wins[o] < 0 && inc) begin
          if (m_cnt[o] == BUF_DEPTH) m_ovf = 1'b1;
          else m_cnt[o] = m_cnt[o] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NC-1:0] exp_av;
    int col;
    if (m_valid) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("cyc_vc[%0d]", p),    32'(bus.sa_grant_vc[p]),        32'(e_vc[p]));
        chk($sformatf("cyc_alloc[%0d]", p), 32'(bus.sa_allocated_ports[p]), 32'(e_alloc[p]));
        chk($sformatf("cyc_gv[%0d]", p),    32'(bus.sa_grant_valid[p]),     32'(e_alloc[p] != '0));
      end
      for (int o = 0; o < NC; o++) exp_av[o] = (m_cnt[o] != 0);
      chk("cyc_avail", 32'(bus.credit_avail), 32'(exp_av));
      chk("cyc_ovf", 32'(bus.credit_overflow), 32'(m_ovf));
      for (int o = 0; o < NP; o++) begin
        col = 0;
        for (int p = 0; p < NP; p++) col += int'(bus.sa_allocated_ports[p][o]);
        chk($sformatf("inv_col[%0d]", o), 32'(col <= 1), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bus.sa_req                  = '0;
    bus.sa_req_port             = '0;
    bus.dwnstr_credit_increment = '0;
  endtask

  task automatic rqraw(input int p, input int v, input port_onehot_t pt);
    bus.sa_req[p*NV + v]      = 1'b1;
    bus.sa_req_port[p*NV + v] = pt;
  endtask

  task automatic rq(input int p, input int v, input int o);
    rqraw(p, v, port_onehot_t'(1) << o);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ng, nl, w;
    int conf_exp [4];
    conf_exp = '{0, 2, 0, 2};
    clr();
    reset = 1'b1;
    tick(); tick();
    chk("rst_gv",    32'(bus.sa_grant_valid),  32'd0);
    chk("rst_avail", 32'(bus.credit_avail),    32'hF);
    chk("rst_ovf",   32'(bus.credit_overflow), 32'd0);
    reset = 1'b0;

    // single request: input 1 VC 2 -> port 0
    rq(1, 2, 0);
    tick();
    chk("single_vc",    32'(bus.sa_grant_vc[1]),        32'b0100);
    chk("single_port",  32'(bus.sa_allocated_ports[1]), 32'b00001);
    chk("single_cnt",   32'(m_cnt[0]),                  32'd3);
    clr();
    tick();
    chk("idle_gv", 32'(bus.sa_grant_valid), 32'd0);
    bus.dwnstr_credit_increment[0] = 1'b1;
    tick();
    clr();

    // conflict on port 3 with credits returned each cycle
    rq(0, 0, 3); rq(2, 1, 3);
    bus.dwnstr_credit_increment[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      w = bus.sa_allocated_ports[0][3] ? 0 : (bus.sa_allocated_ports[2][3] ? 2 : -1);
      chk($sformatf("conflict_win%0d", k), 32'(w), 32'(conf_exp[k]));
    end
    chk("conflict_cnt3", 32'(m_cnt[3]), 32'd4);
    chk("conflict_p1_0", 32'(m_p1[0]),  32'd1);
    chk("conflict_p1_2", 32'(m_p1[2]),  32'd2);
    clr();
    tick();

    // credit exhaustion on port 1
    rq(0, 0, 1);
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      ng += int'(bus.sa_allocated_ports[0][1]);
    end
    chk("exh_grants", 32'(ng), 32'd4);
    chk("exh_avail1", 32'(bus.credit_avail[1]), 32'd0);
    bus.dwnstr_credit_increment[1] = 1'b1;
    tick();
    ng = int'(bus.sa_allocated_ports[0][1]);
    bus.dwnstr_credit_increment[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ng += int'(bus.sa_allocated_ports[0][1]);
    end
    chk("exh_one_more", 32'(ng), 32'd1);
    clr();
    bus.dwnstr_credit_increment[1] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    clr();
    chk("exh_restored", 32'(m_cnt[1]), 32'd4);

    // grant and credit return on port 2 in the same cycle
    rq(3, 1, 2);
    bus.dwnstr_credit_increment[2] = 1'b1;
    tick();
    chk("simul_alloc", 32'(bus.sa_allocated_ports[3]), 32'b00100);
    chk("simul_cnt2",  32'(m_cnt[2]),                  32'd4);
    chk("simul_ovf",   32'(bus.credit_overflow),       32'd0);
    clr();
    tick();

    // overflow on port 0
    bus.dwnstr_credit_increment[0] = 1'b1;
    tick();
    chk("ovf_set",   32'(bus.credit_overflow), 32'd1);
    chk("ovf_cnt0",  32'(m_cnt[0]),            32'd4);
    chk("ovf_avail", 32'(bus.credit_avail),    32'hF);
    clr();
    tick(); tick();
    chk("ovf_sticky", 32'(bus.credit_overflow), 32'd1);

    // local input vs input 0 on port 1
    rq(4, 0, 1); rq(0, 1, 1);
    nl = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nl += int'(bus.sa_allocated_ports[4][1]);
    end
`ifdef SA_LOCAL_PRIO_EN
    chk("local_wins", 32'(nl), 32'd3);
`else
    chk("local_wins", 32'(nl), 32'd2);
`endif
    clr();
    tick();

    // malformed encodings skipped by stage 1
    rqraw(2, 3, 5'b00011);
    rqraw(2, 2, 5'b00000);
    rq(2, 0, 4);
    tick();
    chk("malformed_vc",   32'(bus.sa_grant_vc[2]),        32'b0001);
    chk("malformed_port", 32'(bus.sa_allocated_ports[2]), 32'b10000);
    clr();

    // every input to a distinct output
    rq(0, 3, 4); rq(1, 1, 2); rq(2, 0, 0); rq(3, 2, 1); rq(4, 1, 3);
    tick();
    chk("all_gv", 32'(bus.sa_grant_valid), 32'b11111);
    clr();
    tick();

    // reset during traffic
    rq(1, 0, 0); rq(3, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_gv",    32'(bus.sa_grant_valid),  32'd0);
    chk("mid_rst_avail", 32'(bus.credit_avail),    32'hF);
    chk("mid_rst_ovf",   32'(bus.credit_overflow), 32'd0);
    reset = 1'b0;
    clr();

    // back-to-back grants of one VC
    rq(1, 0, 2);
    ng = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ng += int'(bus.sa_grant_vc[1][0]);
    end
    chk("b2b_grants", 32'(ng), 32'd3);
    clr();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
